// File: rtl/cp0_exc_sequencer.sv
// cp0_exc_sequencer: sequences exception entry / ERET exit through the single CP0 write port
// Optional build macro: EXC_IRQ_SYNC_EN puts irq through a 2-flop synchronizer before masking.
// Ports:
//   clk, rst (sync, active-low)          clock and reset
//   exc_req[2:0] {teq,break,syscall}     synchronous exception requests
//   irq[NUM_IRQ-1:0]                     level-sensitive interrupt lines
//   eret                                 ERET in execute
//   pc, cp0_status, cp0_epc              faulting PC and current CP0 status/EPC
//   cpu_mtc0, cpu_rd, cpu_wdata          CPU mtc0 write request (held until !stall)
//   cp0_we, cp0_addr, cp0_wdata          shared CP0 write port
//   stall, busy                          pipeline freeze / FSM not idle
//   pc_load, pc_target                   one-cycle PC redirect
//   exc_code                             cause code of the most recent entry
module cp0_exc_sequencer #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         exc_req,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               eret,
  input  logic [31:0]        pc,
  input  logic [31:0]        cp0_status,
  input  logic [31:0]        cp0_epc,
  input  logic               cpu_mtc0,
  input  logic [4:0]         cpu_rd,
  input  logic [31:0]        cpu_wdata,
  output logic               cp0_we,
  output logic [4:0]         cp0_addr,
  output logic [31:0]        cp0_wdata,
  output logic               stall,
  output logic               pc_load,
  output logic [31:0]        pc_target,
  output logic               busy,
  output logic [4:0]         exc_code
);
  typedef enum logic [2:0] {IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, VECTOR, RESTORE, RETURN} state_t;
  state_t state, state_n;
  logic [31:0] pc_q;
  logic [4:0] code_q, code_n;
  logic [NUM_IRQ-1:0] irq_s;
  logic teq_ok, brk_ok, sys_ok, irq_ok, take;
`ifdef EXC_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] irq_m;
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_m <= '0;
      irq_s <= '0;
    end else begin
      irq_m <= irq;
      irq_s <= irq_m;
    end
  end
`else
  assign irq_s = irq;
`endif
  assign teq_ok = cp0_status[0] & cp0_status[3] & exc_req[2];
  assign brk_ok = cp0_status[0] & cp0_status[2] & exc_req[1];
  assign sys_ok = cp0_status[0] & cp0_status[1] & exc_req[0];
  assign irq_ok = cp0_status[0] & |(irq_s & cp0_status[8 +: NUM_IRQ]);
  assign take   = teq_ok | brk_ok | sys_ok | irq_ok;
  // every interrupt line shares cause code 0, so only the synchronous sources need ranking
  assign code_n = teq_ok ? 5'd13 : brk_ok ? 5'd9 : sys_ok ? 5'd8 : 5'd0;
  assign busy     = state != IDLE;
  assign exc_code = code_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      pc_q   <= '0;
      code_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && take) begin
        pc_q   <= pc;
        code_q <= code_n;
      end
    end
  end
  always_comb begin
    state_n   = state;
    cp0_we    = 1'b0;
    cp0_addr  = '0;
    cp0_wdata = '0;
    stall     = state != IDLE;
    pc_load   = 1'b0;
    pc_target = '0;
    case (state)
      IDLE: begin
        if (take) begin
          stall   = 1'b1;
          state_n = SAVE_EPC;
        end else if (eret) begin
          stall   = 1'b1;
          state_n = RESTORE;
        end else if (cpu_mtc0) begin
          cp0_we    = 1'b1;
          cp0_addr  = cpu_rd;
          cp0_wdata = cpu_wdata;
        end
      end
      SAVE_EPC: begin
        cp0_we    = 1'b1;
        cp0_addr  = 5'd14;
        cp0_wdata = pc_q;
        state_n   = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        cp0_we    = 1'b1;
        cp0_addr  = 5'd13;
        cp0_wdata = {25'b0, code_q, 2'b0};
        state_n   = SAVE_STATUS;
      end
      SAVE_STATUS: begin
        cp0_we    = 1'b1;
        cp0_addr  = 5'd12;
        cp0_wdata = cp0_status << 5;
        state_n   = VECTOR;
      end
      VECTOR: begin
        pc_load   = 1'b1;
        pc_target = EXC_VECTOR;
        state_n   = IDLE;
      end
      RESTORE: begin
        cp0_we    = 1'b1;
        cp0_addr  = 5'd12;
        cp0_wdata = cp0_status >> 5;
        state_n   = RETURN;
      end
      RETURN: begin
        pc_load   = 1'b1;
        pc_target = cp0_epc;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
